// File: rtl/loadable_down_counter_pkg.sv
// Shared definitions for the loadable down counter: FSM state encodings and default width.
package loadable_down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/loadable_down_counter.sv
// Loadable down counter with one-shot / periodic modes and a registered terminal-count pulse.
module loadable_down_counter
    import loadable_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = data;
            reload_d = data;
            state_d  = (data != '0) ? ST_RUN : ST_DONE;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_RUN: begin
                    if (en) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (count_q == WIDTH'(1)) begin
                            count_d = '0;
                            tc_d    = 1'b1;
                            if (!auto_reload) state_d = ST_DONE;
                        end else if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            // Mode dropped to one-shot while parked at zero: finish without a second tc.
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);

endmodule

// File: doc/loadable_down_counter.md
LOADABLE_DOWN_COUNTER -- requirements
Module: loadable_down_counter

Interface
REQ-001 Parameter: WIDTH, 4, counter and data width in bits (>= 2).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: load  input  1  load data into count and the reload register.
REQ-005 Port: data  input  WIDTH  load value.
REQ-006 Port: en  input  1  count enable; decrement only when high.
REQ-007 Port: auto_reload  input  1  1 = periodic mode, 0 = one-shot mode.
REQ-008 Port: count  output  WIDTH  current count, registered.
REQ-009 Port: tc  output  1  terminal-count pulse, registered, high one cycle.
REQ-010 Port: busy  output  1  high while in RUN.
REQ-011 Port: done  output  1  high while in DONE.

Function
REQ-012 FSM states: IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-013 Priority, every cycle: rst > load > en; auto_reload sampled each cycle, not latched.
REQ-014 load in any state: count <= data; reload_reg <= data; state <= RUN if data != 0, else DONE; tc <= 0.
REQ-015 IDLE with no load: count, reload_reg held; en ignored; tc = 0.
REQ-016 RUN, en=1, count > 1: count <= count - 1; tc <= 0.
REQ-017 RUN, en=1, count == 1: count <= 0; tc <= 1 for exactly the first cycle count reads 0; state <= DONE if auto_reload=0, else stays RUN.
REQ-018 RUN, en=1, count == 0 (periodic mode only): count <= reload_reg; tc <= 0; period is reload_reg+1 enabled cycles.
REQ-019 RUN, en=1, count == 0, auto_reload=0 (mode switched mid-run): state <= DONE; count held at 0; no second tc.
REQ-020 RUN, en=0: count, state held; tc <= 0.
REQ-021 DONE with no load: count held at 0; en ignored; tc = 0.
REQ-022 No underflow: count never wraps from 0 to all-ones.
REQ-023 Load of 0 with auto_reload=1: enters DONE; no tc; no reload loop.
REQ-024 load coincident with the count==1 cycle: the load wins and tc stays 0.

Reset
REQ-025 On rst=1 at a clock edge: count=0, reload_reg=0, tc=0, state=IDLE (busy=0, done=0), regardless of load/en.
REQ-026 Reset mid-count discards the count in progress; no tc is generated.

Structure
REQ-027 A shared counter definitions package/include holds the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH.
REQ-028 The block is one module with no sub-modules: the state register, the count/reload registers and the tc register live in one clocked process, and next-state logic is a separate combinational process.

Verification
REQ-029 Reset: assert rst for 1 cycle, load=1 data=4'd10 during reset -> count=0, tc=0, busy=0, done=0 after reset.
REQ-030 One-shot: load 4'd10, en=1, auto_reload=0 -> count 10,9,...,1,0 on consecutive cycles; tc=1 only on the cycle count=0; done=1 and count holds 0 for 20 further cycles.
REQ-031 Periodic: load 4'd3, en=1, auto_reload=1 -> count 3,2,1,0,3,2,1,0; tc pulses every 4 cycles; busy stays 1.
REQ-032 Hold and priority: at count=4'd5 drop en for 3 cycles -> count stays 5; then load=1 with en=1, data=4'd12 -> next count=12, not 4.
REQ-033 Reset mid-operation: at count=4'd6 in RUN assert rst -> next count=0, IDLE, no tc; en=1 afterwards keeps count at 0.
REQ-034 Zero load: load 4'd0 with auto_reload=1 -> DONE immediately, tc never asserted, count=0.
